id_ex_stage: RTL and testbench

// - ID/EX pipeline register of the 5-stage RV32I core, with load-use hazard detection, bubble insertion and branch flush.
// - Captures decoded operands and control from ID and presents them to EX.
// - Raddr1_e/Raddr2_e/Waddr_e/RegWrite_e feed the EX-stage forwarding unit; MEM-side stall requests freeze it.

---
 rtl/core_pkg.sv | 37 +++
 rtl/hazard_detect.sv | 31 +++
 rtl/id_ex_stage.sv | 108 ++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU operation codes and the
// packed control bundle carried down the pipeline.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;
  localparam int REG_AW  = 5;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  // All-zero control makes a bubble architecturally inert: no write, no memory access.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection and front-end stall request for the
// ID/EX boundary.
module hazard_detect (
  input  logic        valid_e,
  input  logic        mem_read_e,
  input  logic [4:0]  Waddr_e,
  input  logic        valid_d,
  input  logic        use_rs1_d,
  input  logic [4:0]  Raddr1_d,
  input  logic        use_rs2_d,
  input  logic [4:0]  Raddr2_d,
  input  logic        flush_eff,
  input  logic        freeze,
  output logic        load_use,
  output logic        stall_fd
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = use_rs1_d && (Raddr1_d == Waddr_e);
  assign rs2_hit = use_rs2_d && (Raddr2_d == Waddr_e);

  // x0 is hard-wired zero, so a load targeting it can never be a true dependency.
  assign load_use = valid_e && mem_read_e && (Waddr_e != 5'd0) && valid_d &&
                    (rs1_hit || rs2_hit);

  // An instruction being flushed must not hold the front end, or the redirect stalls.
  assign stall_fd = freeze || (load_use && !flush_eff);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion on load-use hazards, branch
// flush (including flushes that arrive during a MEM freeze) and saturating counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   rs1_data_d,
  input  logic [XLEN-1:0]   rs2_data_d,
  input  logic [XLEN-1:0]   imm_d,
  input  logic [REG_AW-1:0] Raddr1_d,
  input  logic              use_rs1_d,
  input  logic [REG_AW-1:0] Raddr2_d,
  input  logic              use_rs2_d,
  input  logic [REG_AW-1:0] Waddr_d,
  input  ctrl_t             ctrl_d,
  input  logic              flush_e,
  input  logic              freeze,
  output logic              valid_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   rs1_data_e,
  output logic [XLEN-1:0]   rs2_data_e,
  output logic [XLEN-1:0]   imm_e,
  output logic [REG_AW-1:0] Raddr1_e,
  output logic [REG_AW-1:0] Raddr2_e,
  output logic [REG_AW-1:0] Waddr_e,
  output ctrl_t             ctrl_e,
  output logic              stall_fd,
  output logic [PERF_W-1:0] load_use_cnt,
  output logic [PERF_W-1:0] flush_cnt
);

  logic flush_pending;
  logic flush_eff;
  logic load_use;

  assign flush_eff = flush_e || flush_pending;

  hazard_detect u_hazard_detect (
    .valid_e    (valid_e),
    .mem_read_e (ctrl_e.mem_read),
    .Waddr_e    (Waddr_e),
    .valid_d    (valid_d),
    .use_rs1_d  (use_rs1_d),
    .Raddr1_d   (Raddr1_d),
    .use_rs2_d  (use_rs2_d),
    .Raddr2_d   (Raddr2_d),
    .flush_eff  (flush_eff),
    .freeze     (freeze),
    .load_use   (load_use),
    .stall_fd   (stall_fd)
  );

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values of flush_pending/valid_e/ctrl_e that feed hazard_detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e       <= 1'b0;
      pc_e          <= '0;
      rs1_data_e    <= '0;
      rs2_data_e    <= '0;
      imm_e         <= '0;
      Raddr1_e      <= '0;
      Raddr2_e      <= '0;
      Waddr_e       <= '0;
      ctrl_e        <= CTRL_BUBBLE;
      flush_pending <= 1'b0;
      load_use_cnt  <= '0;
      flush_cnt     <= '0;
    end else if (freeze) begin
      // Remember a redirect seen while frozen so it still kills ID once MEM releases.
      if (flush_e) flush_pending <= 1'b1;
    end else begin
      // Payload is don't-care for a bubble; only valid/ctrl/indices must be inert.
      pc_e       <= pc_d;
      rs1_data_e <= rs1_data_d;
      rs2_data_e <= rs2_data_d;
      imm_e      <= imm_d;
      if (flush_eff) begin
        valid_e       <= 1'b0;
        ctrl_e        <= CTRL_BUBBLE;
        Raddr1_e      <= '0;
        Raddr2_e      <= '0;
        Waddr_e       <= '0;
        flush_pending <= 1'b0;
        if (valid_d && (flush_cnt != '1)) flush_cnt <= flush_cnt + PERF_W'(1);
      end else if (load_use) begin
        valid_e  <= 1'b0;
        ctrl_e   <= CTRL_BUBBLE;
        Raddr1_e <= '0;
        Raddr2_e <= '0;
        Waddr_e  <= '0;
        if (load_use_cnt != '1) load_use_cnt <= load_use_cnt + PERF_W'(1);
      end else begin
        valid_e  <= valid_d;
        ctrl_e   <= valid_d ? ctrl_d   : CTRL_BUBBLE;
        Raddr1_e <= valid_d ? Raddr1_d : '0;
        Raddr2_e <= valid_d ? Raddr2_d : '0;
        Waddr_e  <= valid_d ? Waddr_d  : '0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/freeze/reset cases
// plus randomized traffic against a behavioural model of the ID->EX transfer rules.
module tb_id_ex_stage;
  import core_pkg::*;

  localparam int PW   = 4;
  localparam int CMAX = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_d;
  logic [XLEN-1:0]   pc_d, rs1_data_d, rs2_data_d, imm_d;
  logic [REG_AW-1:0] Raddr1_d, Raddr2_d, Waddr_d;
  logic              use_rs1_d, use_rs2_d;
  ctrl_t             ctrl_d;
  logic              flush_e, freeze;
  logic              valid_e;
  logic [XLEN-1:0]   pc_e, rs1_data_e, rs2_data_e, imm_e;
  logic [REG_AW-1:0] Raddr1_e, Raddr2_e, Waddr_e;
  ctrl_t             ctrl_e;
  logic              stall_fd;
  logic [PW-1:0]     load_use_cnt, flush_cnt;

  id_ex_stage #(.PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .pc_d(pc_d),
    .rs1_data_d(rs1_data_d), .rs2_data_d(rs2_data_d), .imm_d(imm_d),
    .Raddr1_d(Raddr1_d), .use_rs1_d(use_rs1_d), .Raddr2_d(Raddr2_d), .use_rs2_d(use_rs2_d),
    .Waddr_d(Waddr_d), .ctrl_d(ctrl_d), .flush_e(flush_e), .freeze(freeze),
    .valid_e(valid_e), .pc_e(pc_e), .rs1_data_e(rs1_data_e), .rs2_data_e(rs2_data_e),
    .imm_e(imm_e), .Raddr1_e(Raddr1_e), .Raddr2_e(Raddr2_e), .Waddr_e(Waddr_e),
    .ctrl_e(ctrl_e), .stall_fd(stall_fd), .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  localparam ctrl_t C_LW  = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, mem_to_reg:1'b1,
                              alu_src:1'b1, branch:1'b0, jump:1'b0, alu_op:ALU_ADD};
  localparam ctrl_t C_ADD = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
                              alu_src:1'b0, branch:1'b0, jump:1'b0, alu_op:ALU_ADD};

  // Model of what EX should hold, plus the pending-flush flag and event counts.
  typedef struct packed {
    logic              v;
    logic [XLEN-1:0]   pc, a, b, imm;
    logic [REG_AW-1:0] r1, r2, wd;
    ctrl_t             c;
  } ex_t;

  ex_t m_ex;
  bit  m_fp;
  int  m_lu, m_fl;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_load_use();
    bit hit1, hit2;
    hit1 = use_rs1_d && (Raddr1_d == m_ex.wd);
    hit2 = use_rs2_d && (Raddr2_d == m_ex.wd);
    return m_ex.v && m_ex.c.mem_read && (m_ex.wd != 0) && valid_d && (hit1 || hit2);
  endfunction

  function automatic void model_bubble();
    m_ex.v  = 1'b0;
    m_ex.c  = '0;
    m_ex.r1 = '0;
    m_ex.r2 = '0;
    m_ex.wd = '0;
  endfunction

  task automatic check_outputs();
    check("valid_e", 64'(valid_e), 64'(m_ex.v));
    check("ctrl_e", 64'(ctrl_e), 64'(m_ex.c));
    check("Raddr1_e", 64'(Raddr1_e), 64'(m_ex.r1));
    check("Raddr2_e", 64'(Raddr2_e), 64'(m_ex.r2));
    check("Waddr_e", 64'(Waddr_e), 64'(m_ex.wd));
    check("load_use_cnt", 64'(load_use_cnt), 64'(m_lu));
    check("flush_cnt", 64'(flush_cnt), 64'(m_fl));
    if (m_ex.v) begin
      check("pc_e", 64'(pc_e), 64'(m_ex.pc));
      check("rs1_data_e", 64'(rs1_data_e), 64'(m_ex.a));
      check("rs2_data_e", 64'(rs2_data_e), 64'(m_ex.b));
      check("imm_e", 64'(imm_e), 64'(m_ex.imm));
    end
  endtask

  task automatic drive(input bit v, input logic [4:0] r1, input bit u1, input logic [4:0] r2,
                       input bit u2, input logic [4:0] wd, input ctrl_t c,
                       input bit fl, input bit fz);
    valid_d    = v;
    pc_d       = $urandom;
    rs1_data_d = $urandom;
    rs2_data_d = $urandom;
    imm_d      = $urandom;
    Raddr1_d   = r1;
    use_rs1_d  = u1;
    Raddr2_d   = r2;
    use_rs2_d  = u2;
    Waddr_d    = wd;
    ctrl_d     = c;
    flush_e    = fl;
    freeze     = fz;
  endtask

  // Called at a falling edge with ID inputs applied; returns at the next falling edge.
  task automatic step();
    bit lu, fe;
    #1;
    lu = model_load_use();
    fe = flush_e || m_fp;
    check("stall_fd", 64'(stall_fd), 64'(freeze || (lu && !fe)));
    @(posedge clk);
    if (freeze) begin
      if (flush_e) m_fp = 1'b1;
    end else if (fe) begin
      model_bubble();
      m_fp = 1'b0;
      if (valid_d && m_fl < CMAX) m_fl++;
    end else if (lu) begin
      model_bubble();
      if (m_lu < CMAX) m_lu++;
    end else begin
      m_ex.v   = valid_d;
      m_ex.pc  = pc_d;
      m_ex.a   = rs1_data_d;
      m_ex.b   = rs2_data_d;
      m_ex.imm = imm_d;
      m_ex.c   = valid_d ? ctrl_d : '0;
      m_ex.r1  = valid_d ? Raddr1_d : '0;
      m_ex.r2  = valid_d ? Raddr2_d : '0;
      m_ex.wd  = valid_d ? Waddr_d : '0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  // Asserts reset in the middle of the low phase and checks the clear before any edge.
  task automatic reset_dut();
    #2 rst = 1'b1;
    #1;
    check("rst_valid_e", 64'(valid_e), 64'd0);
    check("rst_ctrl_e", 64'(ctrl_e), 64'd0);
    check("rst_Waddr_e", 64'(Waddr_e), 64'd0);
    check("rst_lu_cnt", 64'(load_use_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
    m_ex = '0;
    m_fp = 1'b0;
    m_lu = 0;
    m_fl = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ctrl_t rc;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, '0, 0, 0);
    m_ex = '0; m_fp = 0; m_lu = 0; m_fl = 0;
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // lw x5 then dependent add: one bubble, then the add enters EX.
    drive(1, 5'd2, 1, 5'd0, 0, 5'd5, C_LW, 0, 0);  step();
    drive(1, 5'd5, 1, 5'd1, 1, 5'd6, C_ADD, 0, 0); step();
    check("lu_bubble_valid", 64'(valid_e), 64'd0);
    check("lu_cnt_one", 64'(load_use_cnt), 64'd1);
    step();
    check("lu_add_enters", 64'(Waddr_e), 64'd6);

    // Load to x0 followed by a reader of x0: no hazard.
    reset_dut();
    drive(1, 5'd2, 1, 5'd0, 0, 5'd0, C_LW, 0, 0);  step();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd6, C_ADD, 0, 0);
    #1 check("x0_no_stall", 64'(stall_fd), 64'd0);
    step();
    check("x0_add_valid", 64'(valid_e), 64'd1);
    check("x0_lu_cnt", 64'(load_use_cnt), 64'd0);

    // Flush coinciding with load-use: flush wins, no front-end stall.
    reset_dut();
    drive(1, 5'd2, 1, 5'd0, 0, 5'd5, C_LW, 0, 0);  step();
    drive(1, 5'd5, 1, 5'd1, 1, 5'd6, C_ADD, 1, 0);
    #1 check("flush_lu_stall", 64'(stall_fd), 64'd0);
    step();
    check("flush_lu_flushcnt", 64'(flush_cnt), 64'd1);
    check("flush_lu_lucnt", 64'(load_use_cnt), 64'd0);

    // Flush pulsed during a 3-cycle freeze survives until freeze drops.
    reset_dut();
    drive(1, 5'd1, 1, 5'd2, 1, 5'd6, C_ADD, 0, 0); step();
    drive(1, 5'd3, 1, 5'd4, 1, 5'd7, C_ADD, 1, 1); step();
    drive(1, 5'd3, 1, 5'd4, 1, 5'd7, C_ADD, 0, 1); step(); step();
    check("freeze_hold", 64'(Waddr_e), 64'd6);
    drive(1, 5'd3, 1, 5'd4, 1, 5'd9, C_ADD, 0, 0); step();
    check("freeze_flush_bubble", 64'(valid_e), 64'd0);
    check("freeze_flush_cnt", 64'(flush_cnt), 64'd1);

    // Reset during freeze discards the pending flush.
    reset_dut();
    drive(1, 5'd1, 1, 5'd2, 1, 5'd6, C_ADD, 0, 0); step();
    drive(1, 5'd1, 1, 5'd2, 1, 5'd8, C_ADD, 1, 1); step();
    reset_dut();
    drive(1, 5'd1, 1, 5'd2, 1, 5'd10, C_ADD, 0, 0); step();
    check("rst_clears_pending", 64'(valid_e), 64'd1);

    // Drive the load-use counter past its ceiling.
    reset_dut();
    for (int i = 0; i < CMAX + 3; i++) begin
      drive(1, 5'd1, 1, 5'd0, 0, 5'd7, C_LW, 0, 0);  step();
      drive(1, 5'd7, 1, 5'd2, 1, 5'd8, C_ADD, 0, 0); step(); step();
    end
    check("lu_cnt_saturated", 64'(load_use_cnt), 64'(CMAX));

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) reset_dut();
      rc          = ctrl_t'(CTRL_W'($urandom));
      rc.alu_op   = alu_op_e'(ALUOP_W'($urandom_range(0, 9)));
      rc.mem_read = ($urandom_range(0, 9) < 4);
      drive($urandom_range(0, 9) < 8,
            5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), rc,
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 15);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
